ntt_alu_pipe: RTL and testbench
===============================

# ntt_alu_pipe

Pipelined, width-parametrised successor to the Hack-style six-control-bit ALU. Each operation is accepted through a valid/ready handshake and passes through two register stages: operand conditioning, then compute and flags. Results come back with zr/ng plus carry and overflow flags. It sits between the CPU's operand-fetch stage and writeback, so the ALU's combinational depth no longer limits fmax and writeback can stall the datapath.

## Interface
- WIDTH, 16, datapath width in bits; legal range ≥ 2.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  block accepts the operation this cycle.
- x  input  WIDTH  operand x.
- y  input  WIDTH  operand y.
- ctrl  input  6  {zx,nx,zy,ny,f,no}, with zx at bit 5 and no at bit 0.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  downstream consumes the result this cycle.
- out  output  WIDTH  result.
- zr  output  1  out == 0.
- ng  output  1  out[WIDTH-1].
- co  output  1  carry-out of the adder (see Configuration).
- ov  output  1  signed overflow of the adder (see Configuration).

## Operation
- Transfers:
  - An input transfer occurs when in_valid && in_ready at a rising edge.
  - An output transfer occurs when out_valid && out_ready at a rising edge.
- Stage 1 (S1) registers the conditioned operands, f, no and a valid bit:
  - xa = zx ? 0 : x; then xa = nx ? ~xa : xa.
  - yb = zy ? 0 : y; then yb = ny ? ~yb : yb.
- Stage 2 (S2) computes and registers the result and flags:
  - sum = xa + yb, computed at WIDTH+1 bits.
  - r = f ? sum[WIDTH-1:0] : (xa & yb).
  - out = no ? ~r : r.
  - zr = (out == 0); ng = out[WIDTH-1].
  - co = f & sum[WIDTH].
  - ov = f & (xa[msb] == yb[msb]) & (sum[msb] != xa[msb]).
  - co and ov describe the add before the no inversion. They are 0 when f=0.
- Flow control:
  - Each stage advances when its successor is empty or is being drained the same cycle.
  - s2_adv = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_adv. This is a combinational path from out_ready to in_ready.
- Ordering: results leave in acceptance order. No operation is dropped or duplicated.
- Stall: while out_valid && !out_ready, out, zr, ng, co and ov hold stable.
- Bubbles: an empty S1 that advances clears out_valid only if out_ready was high. Otherwise S2 holds.
- Reset:
  - s1_valid=0 and out_valid=0.
  - out=0, zr=1, ng=0, co=0, ov=0. S1 data registers are cleared to 0.
  - Reset during operation discards both in-flight operations. No output transfer occurs on the reset edge.
  - in_ready is 1 in the first cycle after reset.

## Timing
- Latency is 2 cycles. An operation accepted at edge N shows out_valid=1 with its result after edge N+1. That makes it consumable at edge N+2 at the earliest.
- Throughput is one operation per cycle while out_ready stays high.
- Capacity is two operations in flight. With out_ready held low from empty, exactly two operations are accepted, then in_ready=0.
- Simultaneous accept and drain in one cycle is legal at both stages. A full pipe with out_ready=1 still has in_ready=1.
- All registers update only on the rising edge of clk. There are no latches and no asynchronous paths.

## Configuration
- Macro NTT_ALU_PIPE_CARRY_EN.
  - Defined: the adder is WIDTH+1 bits, and co/ov are computed and registered as in Operation.
  - Undefined: the adder is WIDTH bits, and co and ov are constant 0 (ports remain present). All other behaviour is identical.
- Benches run in both builds. The flag checks in the Test plan apply only with the macro defined; without it the bench checks co=ov=0.

## Test plan
- Reset, then x=5, y=3, ctrl=000010, out_ready=1 → after 2 edges out=0x0008, zr=0, ng=0, co=0, ov=0; out_valid=0 the cycle after.
- x=3, y=5, ctrl=010011 (x−y) → out=0xFFFE, ng=1, zr=0. Then ctrl=101010 (constant 0) → out=0x0000, zr=1.
- Adder flags:
  - x=0x7FFF, y=0x0001, ctrl=000010 → out=0x8000, ng=1, ov=1, co=0.
  - x=0xFFFF, y=0x0001 → out=0x0000, zr=1, co=1, ov=0.
- Backpressure: issue 4 back-to-back ops (x=1..4, y=0, ctrl=001100 meaning out=x) with out_ready=0 for the first 5 cycles → in_ready=0 after 2 accepts, out holds 1. On releasing out_ready, outputs are 1, 2, 3, 4 on consecutive cycles.
- Reset mid-flight: two ops in the pipe, assert reset for one edge → out_valid=0, out=0, zr=1, in_ready=1. The next op x=7, ctrl=001100 returns out=7 after 2 edges.
- Width: WIDTH=8 instance, x=0x80, y=0x80, ctrl=000010 → out=0x00, zr=1, co=1, ov=1.

Source files
------------

// File: rtl/ntt_alu_pipe.sv
// rtl/ntt_alu_pipe.sv - two-stage pipelined Hack-style ALU with valid/ready flow control; carry/overflow flags enabled by NTT_ALU_PIPE_CARRY_EN
module ntt_alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             co,
  output logic             ov
);

  // ctrl field positions: {zx,nx,zy,ny,f,no}
  localparam int CTRL_ZX = 5;
  localparam int CTRL_NX = 4;
  localparam int CTRL_ZY = 3;
  localparam int CTRL_NY = 2;
  localparam int CTRL_F  = 1;
  localparam int CTRL_NO = 0;

  localparam int MSB = WIDTH - 1;

  // Stage 1 state: conditioned operands plus the two controls still needed
  logic             s1_valid;
  logic [WIDTH-1:0] s1_xa;
  logic [WIDTH-1:0] s1_yb;
  logic             s1_f;
  logic             s1_no;

  // Handshake signals
  logic s2_adv;
  logic in_fire;

  // Combinational results feeding each register stage
  logic [WIDTH-1:0] xa_d;
  logic [WIDTH-1:0] yb_d;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] out_d;

  // S2 may load whenever it is empty or its current result leaves this cycle;
  // S1 in turn may load whenever it is empty or S2 is taking its contents.
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign in_fire  = in_valid && in_ready;

  // Operand conditioning: optional zeroing followed by optional inversion
  always_comb begin
    xa_d = ctrl[CTRL_ZX] ? '0 : x;
    if (ctrl[CTRL_NX]) begin
      xa_d = ~xa_d;
    end
    yb_d = ctrl[CTRL_ZY] ? '0 : y;
    if (ctrl[CTRL_NY]) begin
      yb_d = ~yb_d;
    end
  end

  // Stage 1 register: accept a new operation or fill with a bubble when advancing
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_xa    <= '0;
      s1_yb    <= '0;
      s1_f     <= 1'b0;
      s1_no    <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_fire) begin
        s1_xa <= xa_d;
        s1_yb <= yb_d;
        s1_f  <= ctrl[CTRL_F];
        s1_no <= ctrl[CTRL_NO];
      end
    end
  end

`ifdef NTT_ALU_PIPE_CARRY_EN
  // Adder carries one extra bit so the carry-out is visible
  logic [WIDTH:0] sum;
  logic           co_d;
  logic           ov_d;

  assign sum  = {1'b0, s1_xa} + {1'b0, s1_yb};
  // Flags describe the raw add, before any output inversion, and vanish for AND
  assign co_d = s1_f & sum[WIDTH];
  assign ov_d = s1_f & (s1_xa[MSB] == s1_yb[MSB]) & (sum[MSB] != s1_xa[MSB]);
`else
  // Adder truncated to the datapath width; no flags are produced
  logic [WIDTH-1:0] sum;

  assign sum = s1_xa + s1_yb;
`endif

  // Function select and optional output inversion
  always_comb begin
    r_d   = s1_f ? sum[WIDTH-1:0] : (s1_xa & s1_yb);
    out_d = s1_no ? ~r_d : r_d;
  end

  // Stage 2 register: result and zero/negative flags, held while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out       <= '0;
      zr        <= 1'b1;
      ng        <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out <= out_d;
        zr  <= (out_d == '0);
        ng  <= out_d[MSB];
      end
    end
  end

`ifdef NTT_ALU_PIPE_CARRY_EN
  // Stage 2 carry/overflow registers, loaded alongside the result
  always_ff @(posedge clk) begin
    if (reset) begin
      co <= 1'b0;
      ov <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      co <= co_d;
      ov <= ov_d;
    end
  end
`else
  assign co = 1'b0;
  assign ov = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_alu_pipe.sv
// tb/tb_ntt_alu_pipe.sv - directed self-checking bench for ntt_alu_pipe (16-bit and 8-bit instances)
module tb_ntt_alu_pipe;

  logic        clk;
  logic        reset;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic [5:0]  ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        zr;
  logic        ng;
  logic        co;
  logic        ov;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  x8;
  logic [7:0]  y8;
  logic [5:0]  ctrl8;
  logic        out_valid8;
  logic        out_ready8;
  logic [7:0]  out8;
  logic        zr8;
  logic        ng8;
  logic        co8;
  logic        ov8;

  int n_pass;
  int n_fail;
  int n_total;

  ntt_alu_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zr        (zr),
    .ng        (ng),
    .co        (co),
    .ov        (ov)
  );

  ntt_alu_pipe #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .x         (x8),
    .y         (y8),
    .ctrl      (ctrl8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out       (out8),
    .zr        (zr8),
    .ng        (ng8),
    .co        (co8),
    .ov        (ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Flags only exist in the carry build; otherwise they must read 0
  function automatic logic flag(input logic v);
`ifdef NTT_ALU_PIPE_CARRY_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  // Issue one op on the 16-bit DUT with out_ready high and check its result
  task automatic run_op(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                        input logic [5:0] cv, input logic [15:0] e_out, input logic e_zr,
                        input logic e_ng, input logic e_co, input logic e_ov);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x         = xv;
    y         = yv;
    ctrl      = cv;
    tick();
    in_valid = 1'b0;
    chk({tag, ".valid_n1"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".out"}, 32'(out), 32'(e_out));
    chk({tag, ".zr"}, 32'(zr), 32'(e_zr));
    chk({tag, ".ng"}, 32'(ng), 32'(e_ng));
    chk({tag, ".co"}, 32'(co), 32'(flag(e_co)));
    chk({tag, ".ov"}, 32'(ov), 32'(flag(e_ov)));
    tick();
    chk({tag, ".drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    n_pass     = 0;
    n_fail     = 0;
    n_total    = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    x          = '0;
    y          = '0;
    ctrl       = '0;
    out_ready  = 1'b1;
    in_valid8  = 1'b0;
    x8         = '0;
    y8         = '0;
    ctrl8      = '0;
    out_ready8 = 1'b1;

    tick();
    tick();
    reset = 1'b0;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out", 32'(out), 32'd0);
    chk("rst.zr", 32'(zr), 32'd1);
    chk("rst.ng", 32'(ng), 32'd0);
    chk("rst.co", 32'(co), 32'd0);
    chk("rst.ov", 32'(ov), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    // x+y, x-y (carry set by ~x+y wrap), constant 0, signed overflow, unsigned wrap
    run_op("add", 16'd5, 16'd3, 6'b000010, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sub", 16'd3, 16'd5, 6'b010011, 16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0);
    run_op("zero", 16'h1234, 16'h5678, 6'b101010, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("ovf", 16'h7FFF, 16'h0001, 6'b000010, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op("wrap", 16'hFFFF, 16'h0001, 6'b000010, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("and", 16'hF0F0, 16'h3C3C, 6'b000000, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("nand", 16'hF0F0, 16'h3C3C, 6'b000001, 16'hCFCF, 1'b0, 1'b1, 1'b0, 1'b0);

    // Backpressure: pass-through ops 1..4 with out_ready low for five edges
    out_ready = 1'b0;
    in_valid  = 1'b1;
    ctrl      = 6'b001100;
    y         = 16'h0000;
    x         = 16'd1;
    chk("bp.rdy1", 32'(in_ready), 32'd1);
    tick();
    x = 16'd2;
    chk("bp.rdy2", 32'(in_ready), 32'd1);
    tick();
    x = 16'd3;
    chk("bp.full", 32'(in_ready), 32'd0);
    chk("bp.hold_valid", 32'(out_valid), 32'd1);
    chk("bp.hold_out", 32'(out), 32'd1);
    tick();
    tick();
    tick();
    chk("bp.still_full", 32'(in_ready), 32'd0);
    chk("bp.still_out", 32'(out), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp.rdy_comb", 32'(in_ready), 32'd1);
    chk("bp.out1", 32'(out), 32'd1);
    tick();
    x = 16'd4;
    chk("bp.out2", 32'(out), 32'd2);
    chk("bp.v2", 32'(out_valid), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp.out3", 32'(out), 32'd3);
    chk("bp.v3", 32'(out_valid), 32'd1);
    tick();
    chk("bp.out4", 32'(out), 32'd4);
    chk("bp.v4", 32'(out_valid), 32'd1);
    tick();
    chk("bp.empty", 32'(out_valid), 32'd0);

    // Reset with two ops in flight discards both
    out_ready = 1'b0;
    in_valid  = 1'b1;
    ctrl      = 6'b001100;
    x         = 16'd9;
    tick();
    x = 16'd10;
    tick();
    in_valid = 1'b0;
    chk("mid.pre_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid.out_valid", 32'(out_valid), 32'd0);
    chk("mid.out", 32'(out), 32'd0);
    chk("mid.zr", 32'(zr), 32'd1);
    chk("mid.in_ready", 32'(in_ready), 32'd1);
    run_op("post", 16'd7, 16'd0, 6'b001100, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0);

    // 8-bit instance: 0x80 + 0x80 wraps to zero with carry and overflow
    in_valid8 = 1'b1;
    x8        = 8'h80;
    y8        = 8'h80;
    ctrl8     = 6'b000010;
    tick();
    in_valid8 = 1'b0;
    tick();
    chk("w8.valid", 32'(out_valid8), 32'd1);
    chk("w8.out", 32'(out8), 32'h00);
    chk("w8.zr", 32'(zr8), 32'd1);
    chk("w8.co", 32'(co8), 32'(flag(1'b1)));
    chk("w8.ov", 32'(ov8), 32'(flag(1'b1)));
    tick();
    chk("w8.drained", 32'(out_valid8), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
